// File: rtl/seq_bit_serializer_if.sv
// Handshake and serial-output bundle for seq_bit_serializer.
// master: the word producer (drives din/din_valid, observes the rest).
// slave : the serializer itself.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             in;
  logic             in_valid;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, in, in_valid, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, in, in_valid, busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel word to one-bit-per-clock serial stream.
// Optional feature macro: SEQ_SER_PARITY_EN -- when defined, each frame is
// followed by one even-parity bit (XOR of the word); frame length WIDTH+1.
//
// state  | meaning
// IDLE   | no frame in flight, ready for a word once the ready enable is set
// SHIFT  | payload bits on `in`, one per clock, cnt = index of current bit
// PARITY | parity bit on `in` (only with SEQ_SER_PARITY_EN)
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  seq_bit_serializer_if.slave bus
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

`ifdef SEQ_SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             in_q;
  logic             in_valid_q;
  logic             busy_q;
  logic             ready_q;
  logic             rdy_en;
`ifdef SEQ_SER_PARITY_EN
  logic             parity_q;
`endif

  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic             frame_end;
  logic [WIDTH-1:0] sreg_shifted;

  assign bus.din_ready = ready_q & rdy_en;
  assign bus.in        = in_q;
  assign bus.in_valid  = in_valid_q;
  assign bus.busy      = busy_q;

  assign accept       = bus.din_valid & bus.din_ready;
  assign first_bit    = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
  assign next_bit     = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

`ifdef SEQ_SER_PARITY_EN
  assign frame_end = (state == PARITY);
`else
  assign frame_end = (state == SHIFT) && (cnt == LAST);
`endif

  // Keeps din_ready low through the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Frame sequencer; every output is a flop so nothing on in/in_valid
  // depends combinationally on din or din_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      in_q       <= 1'b0;
      in_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else if (state == IDLE || frame_end) begin
      if (accept) begin
        // Load the word and present its first bit next cycle; a word taken
        // in the last bit cycle continues the stream without a gap.
        state      <= SHIFT;
        cnt        <= '0;
        sreg       <= bus.din;
        in_q       <= first_bit;
        in_valid_q <= 1'b1;
        busy_q     <= 1'b1;
        ready_q    <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
        parity_q   <= ^bus.din;
`endif
      end else begin
        state      <= IDLE;
        cnt        <= '0;
        in_q       <= 1'b0;
        in_valid_q <= 1'b0;
        busy_q     <= 1'b0;
        ready_q    <= 1'b1;
      end
    end else if (state == SHIFT && cnt != LAST) begin
      cnt        <= cnt + 1'b1;
      sreg       <= sreg_shifted;
      in_q       <= next_bit;
`ifdef SEQ_SER_PARITY_EN
      ready_q    <= 1'b0;
`else
      // Raise ready one cycle early so it is high during the last bit.
      ready_q    <= (cnt == PENULT);
`endif
    end else begin
`ifdef SEQ_SER_PARITY_EN
      state      <= PARITY;
      cnt        <= '0;
      in_q       <= parity_q;
      ready_q    <= 1'b1;
`else
      state      <= IDLE;
      cnt        <= '0;
      in_q       <= 1'b0;
      in_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/seq_bit_serializer.md
SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word for transfer.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 in  output  1  serial bit stream, one bit per clock; drives the downstream detector's serial input.
REQ-009 in_valid  output  1  `in` carries a payload or parity bit this cycle.
REQ-010 busy  output  1  a word is being shifted out.

Function
REQ-011 A word SHALL be accepted on a rising edge where din_valid=1 and din_ready=1, and not otherwise.
REQ-012 States SHALL be IDLE, SHIFT and PARITY; PARITY exists only when the Configuration macro is defined.
REQ-013 IDLE: din_ready=1 (subject to REQ-024), in=0, in_valid=0, busy=0. On accept, go to SHIFT.
REQ-014 Latency: the first bit of an accepted word SHALL appear on `in` with in_valid=1 in the cycle after the accepting edge.
REQ-015 SHIFT: each bit SHALL be held for exactly one clock. A bit counter SHALL count 0..WIDTH-1, with width ceil(log2(WIDTH)).
REQ-016 Bit order SHALL follow MSB_FIRST. din SHALL be captured into a shift register at accept, so later din changes do not affect the word in flight.
REQ-017 din_ready SHALL be 1 in the last bit cycle of a frame (last payload bit, or the parity bit when parity is enabled), and 0 in all other SHIFT/PARITY cycles.
REQ-018 Back-to-back: if a word is accepted in the last bit cycle, its first bit SHALL follow with no gap; in_valid stays 1 and the state returns to SHIFT.
REQ-019 If no word is accepted in the last bit cycle, the next cycle SHALL be IDLE with in=0 and in_valid=0.
REQ-020 busy SHALL be 1 exactly when the state is SHIFT or PARITY.
REQ-021 in and in_valid SHALL be driven directly from flops, with no combinational path from din or din_valid.
REQ-022 din_valid=1 while din_ready=0 SHALL be ignored, with no side effects.

Reset
REQ-023 While rst_n=0: state=IDLE, counter=0, shift register=0, in=0, in_valid=0, busy=0, din_ready=0.
REQ-024 din_ready SHALL remain 0 for the first clock edge after rst_n rises; this uses a ready-enable flop reset to 0. din_ready follows REQ-013/REQ-017 from then on.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously). No partial bits SHALL resume after release.

Configuration
REQ-026 Macro SEQ_SER_PARITY_EN.
- Defined: after the last payload bit, one PARITY cycle SHALL emit the even-parity bit of the word (XOR of all WIDTH bits) with in_valid=1. Frame length is WIDTH+1.
- Undefined: no PARITY state and no parity logic. Frame length is WIDTH.

Verification
REQ-027 Reset release, din_valid=1 held from time 0 -> no accept on the first edge after release; accept on the second edge; first bit appears the cycle after that.
REQ-028 WIDTH=8, MSB_FIRST=1, din=8'b1001_0010 accepted once, macro off -> `in` = 1,0,0,1,0,0,1,0 over cycles 1..8 with in_valid=1 throughout; cycle 9 in_valid=0; feeding the downstream 10010 detector yields its two overlapping detections.
REQ-029 MSB_FIRST=0, din=8'hA5 -> `in` = 1,0,1,0,0,1,0,1; busy=1 for exactly 8 cycles.
REQ-030 Words 8'hF0 then 8'h0F, din_valid held high -> 16 consecutive valid bits 1111_0000_0000_1111 with no gap; din_ready pulses only in bit cycles 8 and 16.
REQ-031 Macro on, din=8'h07 -> 8 payload bits, then a parity cycle with in=1 and in_valid=1; din_ready=1 only in the parity cycle.
REQ-032 rst_n pulled low during bit 4 of 8'hFF -> in, in_valid and busy go to 0 immediately; after release no residual bits appear and the next accepted word is sent intact.
